// File: rtl/key_conditioner_pkg.sv
// Shared state encoding and default 50 MHz timing for the key conditioner.
package key_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } kc_state_t;

  localparam int DEF_DATA_W          = 14;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_LONG_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;

  // Sizes the shared timing counter to the longest interval it must reach.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous inputs, cleared by the active-low reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Button/switch conditioner: synchronises inputs, debounces the button and emits
// press, release, long-press and auto-repeat strobes with a captured switch word.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_button,
  input  logic [DATA_W-1:0] switch,
  output logic              pressed,
  output logic              press,
  output logic              button_release,
  output logic              long_press,
  output logic              load,
  output logic [DATA_W-1:0] data_out
);

  localparam int MAX_CYC = max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic              btn_n;
  logic              btn_s;
  logic [DATA_W-1:0] sw_s;
  kc_state_t         state;
  logic [CW-1:0]     cnt;

  // Invert before synchronising so btn_s reads 1 while the button is held.
  assign btn_n = ~w_button;

  sync2 #(.W(1)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_n),
    .q     (btn_s)
  );

  sync2 #(.W(DATA_W)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .d     (switch),
    .q     (sw_s)
  );

  // The button level is tested before any terminal count, so a bounce always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pressed        <= 1'b0;
      press          <= 1'b0;
      button_release <= 1'b0;
      long_press     <= 1'b0;
      load           <= 1'b0;
      data_out       <= '0;
    end else begin
      press          <= 1'b0;
      button_release <= 1'b0;
      long_press     <= 1'b0;
      load           <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= HELD;
            cnt      <= '0;
            pressed  <= 1'b1;
            press    <= 1'b1;
            load     <= 1'b1;
            data_out <= sw_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= REPEAT;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (cnt == REPEAT_LAST) begin
            cnt      <= '0;
            load     <= 1'b1;
            data_out <= sw_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            pressed        <= 1'b0;
            button_release <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
